// File: rtl/score_pkg.sv
// score_pkg -- shared definitions for the score display.
//   Segment patterns are active-low {g,f,e,d,c,b,a}.
//   bin2bcd splits a 0..31 score into tens (0..3) and units (0..9)
//   using comparisons only.
package score_pkg;

  localparam int DIV_DEFAULT = 50000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan slot: 0 = score units, 1 = score tens, 2 = best units, 3 = best tens
  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic bcd2_t bin2bcd(input logic [4:0] v);
    bcd2_t r;
    if (v >= 5'd30) begin
      r.tens  = 2'd3;
      r.units = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      r.tens  = 2'd2;
      r.units = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      r.tens  = 2'd1;
      r.units = 4'(v - 5'd10);
    end else begin
      r.tens  = 2'd0;
      r.units = v[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational BCD to 7-segment decoder.
//   bcd : 4-bit digit 0..9 (other codes decode to blank)
//   seg : active-low segment pattern {g,f,e,d,c,b,a}
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// score_display -- 4-digit multiplexed display of current and best score.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   score    : current score 0..31 from the score counter
//   clr_best : level, clears the best-score register
//   seg      : active-low segments {g,f,e,d,c,b,a}, registered
//   an       : active-low digit enables (one low), registered
//   dp       : active-low decimal point, always off
//   best     : best score seen since reset / clear, registered
// Digits 0/1 show the current score, digits 2/3 the best score. After a
// new record the best digits blink for BLINK_FRAMES scan frames.
module score_display
  import score_pkg::*;
#(
  parameter int DIV          = DIV_DEFAULT,
  parameter int BLINK_FRAMES = 64,
  parameter int BLINK_HALF   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] score,
  input  logic       clr_best,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [4:0] best
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PS_MAX     = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES);

  logic [4:0]    score_q;
  logic [PW-1:0] ps_cnt;
  digit_idx_t    dig;
  logic [BW-1:0] blink_cnt;

  logic          wrap;
  logic          frame_end;
  logic          blink_off;
  bcd2_t         sc_bcd;
  bcd2_t         bs_bcd;
  logic [3:0]    digit_val;
  logic          tens_slot;
  logic          best_slot;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  assign dp        = 1'b1;
  assign wrap      = (ps_cnt == PS_MAX);
  assign frame_end = wrap && (dig == 2'd3);
  assign sc_bcd    = bin2bcd(score_q);
  assign bs_bcd    = bin2bcd(best);

  // Off half-periods are the odd-numbered ones counted from the record.
  assign blink_off = (blink_cnt != '0) &&
                     ((((BLINK_FRAMES - int'(blink_cnt)) / BLINK_HALF) % 2) == 1);

  // Slot mux: pick the digit value for the slot being scanned now.
  always_comb begin
    digit_val = sc_bcd.units;
    tens_slot = 1'b0;
    best_slot = 1'b0;
    case (dig)
      2'd0: digit_val = sc_bcd.units;
      2'd1: begin
        digit_val = {2'b00, sc_bcd.tens};
        tens_slot = 1'b1;
      end
      2'd2: begin
        digit_val = bs_bcd.units;
        best_slot = 1'b1;
      end
      default: begin
        digit_val = {2'b00, bs_bcd.tens};
        tens_slot = 1'b1;
        best_slot = 1'b1;
      end
    endcase
  end

  seg7_decode u_decode (
    .bcd (digit_val),
    .seg (dec_seg)
  );

  always_comb begin
    seg_next = dec_seg;
    if ((tens_slot && digit_val == 4'd0) || (best_slot && blink_off))
      seg_next = SEG_BLANK;
    an_next = ~(4'b0001 << dig);
  end

  // Registered stage: input capture, scan counters, best/blink, outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q   <= '0;
      best      <= '0;
      ps_cnt    <= '0;
      dig       <= '0;
      blink_cnt <= '0;
      seg       <= SEG_BLANK;
      an        <= 4'b1111;
    end else begin
      score_q <= score;
      ps_cnt  <= wrap ? '0 : ps_cnt + 1'b1;

      if (wrap) begin
        dig <= dig + 1'b1;
        seg <= seg_next;
        an  <= an_next;
      end

      // Clear beats a record; a record (re)starts the blink even mid-blink.
      if (clr_best) begin
        best      <= '0;
        blink_cnt <= '0;
      end else if (score_q > best) begin
        best      <= score_q;
        blink_cnt <= BLINK_LOAD;
      end else if (frame_end && blink_cnt != '0) begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter DIV, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 64: scan frames the best digits blink after a new record.
REQ-003 Parameter BLINK_HALF, default 8: frames per blink on/off half-period.
REQ-004 clk  in  1  single system clock; all state on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 score  in  5  current score from the upstream score counter, unsigned 0..31.
REQ-007 clr_best  in  1  level; clears the best-score register.
REQ-008 seg  out  7  active-low segments {g,f,e,d,c,b,a}; registered.
REQ-009 an  out  4  active-low digit enables, one-hot-low; registered.
REQ-010 dp  out  1  active-low decimal point; constant 1 (off).
REQ-011 best  out  5  current best score; registered.

Function
REQ-012 score SHALL be registered into score_q every cycle; all downstream logic uses score_q only.
REQ-013 If score_q > best and clr_best=0, best SHALL load score_q next cycle and the blink counter SHALL load BLINK_FRAMES.
REQ-014 clr_best=1 SHALL set best=0 and blink counter=0 next cycle; clr_best wins over a simultaneous new record.
REQ-015 A decrease of score (upstream reset) SHALL NOT change best.
REQ-016 Prescaler SHALL count 0..DIV-1 and wrap; digit index (0..3) SHALL advance 0,1,2,3,0 on each wrap.
REQ-017 A frame ends on the wrap where the digit index goes 3->0; blink counter SHALL decrement by 1 per frame end while nonzero.
REQ-018 Digit map: 0 = score_q units, 1 = score_q tens, 2 = best units, 3 = best tens; an bit i low selects digit i.
REQ-019 Tens = value/10 (0..3), units = value mod 10, using values sampled on the same cycle as the seg/an update.
REQ-020 seg and an SHALL update together on the cycle after prescaler wrap (one-cycle registered latency).
REQ-021 Leading-zero blanking: a tens digit with value 0 SHALL drive seg=7'b1111111 with its an still asserted.
REQ-022 While blink counter nonzero and ((BLINK_FRAMES - counter)/BLINK_HALF) is odd, digits 2 and 3 SHALL drive seg=7'b1111111.
REQ-023 A new record during an active blink SHALL restart the counter at BLINK_FRAMES.
REQ-024 Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-025 On reset: score_q=0, best=0, prescaler=0, digit index=0, blink counter=0.
REQ-026 On reset: an=4'b1111, seg=7'b1111111, dp=1; first digit drives after the first prescaler wrap.
REQ-027 Reset mid-frame or mid-blink SHALL abort the frame and blink with no residual state.

Structure
REQ-028 Shared package score_pkg SHALL hold the segment pattern constants, blank pattern, digit-index type and DIV default.
REQ-029 Sub-module seg7_decode (4-bit BCD in, 7-bit active-low pattern out, combinational) SHALL be instantiated once on the muxed digit.
REQ-030 Binary-to-BCD split SHALL be in-module; no divider IP.

Verification (DIV=4, BLINK_FRAMES=4, BLINK_HALF=1)
REQ-031 Reset, then hold score=0 for 20 cycles -> an cycles 1110,1101,1011,0111 every 4 cycles; seg 1000000 on units digits, 1111111 on tens digits.
REQ-032 score=27 -> digit 0 seg=1111000, digit 1 seg=0100100; best=27 two cycles after score changes.
REQ-033 score 27 then 5 -> best stays 27; digits 2/3 show 7/2; digits 0/1 show 5/blank.
REQ-034 score 3->9 -> digits 2/3 blank on frames 2 and 4 after the record, shown on frames 1 and 3, steady from frame 5.
REQ-035 score=12 with clr_best=1 same cycle -> best=0 next cycle, no blink; after clr_best=0, best=12 and blink starts.
REQ-036 Assert reset mid-blink at digit 2 -> next cycle an=1111, seg=1111111, best=0; scan restarts at digit 0.
